// File: rtl/memory_loader.sv
// Scan-style bulk loader: after an arm cycle on scan_en, LSB-first beats of scan_in
// are assembled into rows and written to `memory` from row 0 upward.
module memory_loader #(
  parameter int WORD_WIDTH = 512,
  parameter int NUM_ROWS   = 128,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic [DATA_WIDTH-1:0] scan_in,
  output logic                  load_done
);

  localparam int BEATS = WORD_WIDTH / DATA_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RPW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  if (WORD_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
    $error("memory_loader: WORD_WIDTH must be a multiple of DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q, state_d;
  logic [RPW-1:0]        row_ptr_q, row_ptr_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic                  done_q, done_d;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] wr_word;

  logic [WORD_WIDTH-1:0] memory [NUM_ROWS-1:0];

  assign load_done = done_q;

  always_comb begin
    state_d    = state_q;
    row_ptr_d  = row_ptr_q;
    beat_cnt_d = beat_cnt_q;
    asm_d      = asm_q;
    done_d     = done_q;
    wr_en      = 1'b0;
    // The current beat merged into earlier beats is exactly the row written on the last beat.
    wr_word    = asm_q;
    wr_word[int'(beat_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = scan_in;

    case (state_q)
      IDLE, DONE: begin
        if (scan_en) begin
          state_d    = LOAD;
          row_ptr_d  = '0;
          beat_cnt_d = '0;
          done_d     = 1'b0;
        end
      end
      LOAD: begin
        if (scan_en) begin
          row_ptr_d  = '0;
          beat_cnt_d = '0;
        end else begin
          asm_d = wr_word;
          if (beat_cnt_q == BCW'(BEATS - 1)) begin
            wr_en      = 1'b1;
            beat_cnt_d = '0;
            row_ptr_d  = row_ptr_q + 1'b1;
            if (row_ptr_q == RPW'(NUM_ROWS - 1)) begin
              state_d   = DONE;
              done_d    = 1'b1;
              row_ptr_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_ptr_q  <= '0;
      beat_cnt_q <= '0;
      asm_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_ptr_q  <= row_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      asm_q      <= asm_d;
      done_q     <= done_d;
    end
  end

  // Row storage has RAM semantics: no reset, contents survive aborts and resets.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      memory[row_ptr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader: full-width and quarter-width beat instances,
// expected rows tracked in a scoreboard queue and a shadow row model.
module tb_memory_loader;

  localparam int NR = 128;

  typedef struct {
    int           row;
    logic [511:0] data;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         scan_en = 1'b0;
  logic [511:0] scan_in = '0;
  logic         load_done;
  logic         scan_en_b = 1'b0;
  logic [127:0] scan_in_b = '0;
  logic         load_done_b;

  exp_t         sb[$];
  logic [511:0] mem_model [NR];
  int           compare_cnt = 0;
  int           fail_cnt = 0;

  always #5 clock = ~clock;

  memory_loader #(.WORD_WIDTH(512), .NUM_ROWS(NR), .DATA_WIDTH(512)) dut (
    .clock(clock), .reset(reset), .scan_en(scan_en), .scan_in(scan_in), .load_done(load_done)
  );

  memory_loader #(.WORD_WIDTH(512), .NUM_ROWS(NR), .DATA_WIDTH(128)) dut_b (
    .clock(clock), .reset(reset), .scan_en(scan_en_b), .scan_in(scan_in_b), .load_done(load_done_b)
  );

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [511:0] data);
    @(negedge clock);
    scan_en = en;
    scan_in = data;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus_b(input logic en, input logic [127:0] data);
    @(negedge clock);
    scan_en_b = en;
    scan_in_b = data;
    @(posedge clock);
    #1;
  endtask

  // Drive one data beat for the full-width DUT and push its expected row.
  task automatic stream_row(input int row, input logic [511:0] data);
    exp_t e;
    e.row  = row;
    e.data = data;
    sb.push_back(e);
    mem_model[row] = data;
    apply_stimulus(1'b0, data);
  endtask

  task automatic drain_sb(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_output($sformatf("%s row%0d", tag, e.row), dut.memory[e.row], e.data);
    end
  endtask

  task automatic check_all_rows(input string tag);
    for (int r = 0; r < NR; r++)
      check_output($sformatf("%s row%0d", tag, r), dut.memory[r], mem_model[r]);
  endtask

  initial begin
    logic [511:0] d;
    logic [127:0] beat;
    exp_t         e;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_output("reset load_done", 512'(load_done), 512'd0);
    check_output("reset load_done_b", 512'(load_done_b), 512'd0);
    @(negedge clock);
    reset = 1'b1;

    // Scenario 1: arm with junk, then 128 random rows
    apply_stimulus(1'b1, rand512());
    check_output("s1 arm load_done", 512'(load_done), 512'd0);
    for (int i = 0; i < NR; i++) begin
      stream_row(i, rand512());
      drain_sb("s1");
      check_output($sformatf("s1 load_done beat%0d", i), 512'(load_done), 512'(i == NR - 1));
    end

    // Scenario 2: data with scan_en low after done is ignored
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, {16{32'hDEADBEEF}});
      check_output($sformatf("s2 load_done hold%0d", i), 512'(load_done), 512'd1);
    end
    check_all_rows("s2");

    // Scenario 3: re-arm after done, rows i*0x11
    apply_stimulus(1'b1, '1);
    check_output("s3 arm load_done", 512'(load_done), 512'd0);
    for (int i = 0; i < NR; i++) begin
      stream_row(i, 512'(i * 17));
      drain_sb("s3");
      check_output($sformatf("s3 load_done beat%0d", i), 512'(load_done), 512'(i == NR - 1));
    end

    // Scenario 4: abort after 50 beats, then full stream of 0xA5
    apply_stimulus(1'b1, '0);
    for (int i = 0; i < 50; i++) begin
      stream_row(i, ~512'(i));
      drain_sb("s4a");
    end
    check_output("s4 load_done before abort", 512'(load_done), 512'd0);
    apply_stimulus(1'b1, rand512());
    check_output("s4 row0 kept after abort", dut.memory[0], ~512'd0);
    for (int i = 0; i < NR; i++) begin
      stream_row(i, {64{8'hA5}});
      drain_sb("s4b");
      if (i == NR - 2) check_output("s4 load_done beat126", 512'(load_done), 512'd0);
    end
    check_output("s4 load_done final", 512'(load_done), 512'd1);
    check_all_rows("s4");

    // Asynchronous reset clears load_done without a clock edge
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_output("async reset load_done", 512'(load_done), 512'd0);
    @(negedge clock);
    reset = 1'b1;

    // Scenario 5: reset at beat 60 leaves rows, later beats without arm ignored
    apply_stimulus(1'b1, '0);
    for (int i = 0; i < 60; i++) stream_row(i, 512'(i) + 512'h1000);
    drain_sb("s5");
    #2 reset = 1'b0;
    #1 check_output("s5 reset load_done", 512'(load_done), 512'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, {16{32'hCAFEF00D}});
    check_output("s5 idle load_done", 512'(load_done), 512'd0);
    check_all_rows("s5");

    // Scenario 6: four 128-bit beats per row, LSB first
    apply_stimulus_b(1'b1, '1);
    for (int r = 0; r < NR; r++) begin
      d = '0;
      for (int b = 0; b < 4; b++) begin
        beat = rand128();
        d[b*128 +: 128] = beat;
        apply_stimulus_b(1'b0, beat);
        if (b == 2) check_output($sformatf("s6 load_done mid row%0d", r), 512'(load_done_b), 512'd0);
      end
      e.row  = r;
      e.data = d;
      sb.push_back(e);
      e = sb.pop_front();
      check_output($sformatf("s6 row%0d", e.row), dut_b.memory[e.row], e.data);
      check_output($sformatf("s6 load_done row%0d", r), 512'(load_done_b), 512'(r == NR - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule
